instr_fetch: RTL

Instruction fetch stage for the rv32 core: owns the program counter, issues word-aligned reads to instruction memory, and buffers returned words in a small FIFO. It delivers one 32-bit instruction plus its PC per handshake to the instruction-decode stage. It is the producer end of the instruction interface that decode consumes. Control-flow redirects from execute flush buffered and in-flight fetches and restart fetch at the new target.

---
 rtl/instr_fetch.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues word reads to imem, and buffers returned words for decode.
// Latency: response in cycle N is presented to decode in N+1; after a redirect in R, the new target is requested in R+1.
// Backpressure: requests are credit limited so that buffered plus owed words never exceed DEPTH; imem responses are never stalled.

module if_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_rdy,
    output logic                   head_vld,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);
    // Generic synchronous FIFO with a single-cycle clear.
    // Latency: a push is visible at the head on the next cycle.
    // Backpressure: a push into a full FIFO is ignored; the caller is expected never to do this.

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = head_vld & pop_rdy;
    assign do_push  = push_vld & ~full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);
    // Fetch PC generation, imem request/response tracking and the decode-facing instruction buffer.
    // Latency: 1 cycle from imem response to instr_valid; first request one cycle after reset release.
    // Backpressure: stalls requests when buffered + owed words reach DEPTH; instr_ready low only fills the buffer.

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]  CREDITS    = (CW + 1)'(DEPTH);
    localparam logic [31:0]  RESET_WORD = {RESET_PC[31:2], 2'b00};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    logic [31:0]  fetch_pc;
    logic [31:0]  rsp_pc;
    logic [31:0]  target_pc;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_count;
    logic [CW:0]   credit_used;
    logic          buf_full;
    logic          run_q;
    logic          req_hs;
    logic          drop_rsp;
    logic          push_vld;
    fetch_entry_t  push_dat;
    fetch_entry_t  head_dat;
    logic          redirect_lsb_unused;

    assign target_pc           = {redirect_pc[31:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Owed responses still hold a buffer slot, so the FIFO can never overflow.
    assign credit_used    = {1'b0, buf_count} + {1'b0, in_flight};
    assign imem_req_valid = run_q & (credit_used < CREDITS) & ~redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign req_hs         = imem_req_valid & imem_req_ready;

    assign drop_rsp = imem_rsp_valid & (drop_cnt != '0);
    assign push_vld = imem_rsp_valid & (drop_cnt == '0) & ~redirect_valid;
    assign push_dat = '{pc: rsp_pc, word: imem_rsp_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            fetch_pc  <= RESET_WORD;
            rsp_pc    <= RESET_WORD;
            in_flight <= '0;
            drop_cnt  <= '0;
        end else begin
            run_q <= 1'b1;
            if (redirect_valid) begin
                // Everything still owed belongs to the old path and is discarded on arrival.
                fetch_pc  <= target_pc;
                rsp_pc    <= target_pc;
                in_flight <= in_flight - CW'(imem_rsp_valid);
                drop_cnt  <= in_flight - CW'(imem_rsp_valid);
            end else begin
                if (req_hs) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push_vld) begin
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (drop_rsp) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                in_flight <= in_flight + CW'(req_hs) - CW'(imem_rsp_valid);
            end
        end
    end

    if_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (redirect_valid),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (instr_ready),
        .head_vld (instr_valid),
        .head_dat (head_dat),
        .count    (buf_count),
        .full     (buf_full)
    );

    assign instruction = head_dat.word;
    assign instr_pc    = head_dat.pc;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_vld && buf_full));

    a_no_unowed_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (in_flight == '0)));

endmodule
